frame_pattern_writer: RTL and testbench

- Synthetic pixel source that feeds the two SDRAM write ports of the 4-port SDRAM controller.
- Produces one RGB888 pixel per accepted cycle as two 16-bit words: WR1 = {R,G}, WR2 = {B,8'h00}.
- Produces matching linear frame-buffer addresses for each pixel.
- Replaces the free-running counters in the camera top level.
- Gives the VGA read path deterministic, frame-aligned content for bring-up before the CCD path exists.

---
 rtl/frame_pattern_writer.sv | 204 ++++++++++++++++++++
 tb/tb_frame_pattern_writer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pattern_writer.sv
// Synthetic RGB888 frame source driving the SDRAM WR1/WR2 ports with linear frame addresses.
// Define PATTERN_CRC_EN to add oCRC, a CRC-16-CCITT over every accepted pixel of the last frame.
module frame_pattern_writer #(
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter logic [22:0] BASE1      = 23'h000000,
  parameter logic [22:0] BASE2      = 23'h100000,
  parameter int          GAP_CYCLES = 16
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iEN,
  input  logic [1:0]  iMODE,
  input  logic        iWR_FULL,
  output logic        oWR,
  output logic [15:0] oWR1_DATA,
  output logic [15:0] oWR2_DATA,
  output logic [22:0] oWR1_ADDR,
  output logic [22:0] oWR2_ADDR,
  output logic [9:0]  oCOL,
  output logic [9:0]  oROW,
  output logic        oFRAME_DONE,
  output logic [7:0]  oFRAME_CNT,
  output logic        oBUSY
`ifdef PATTERN_CRC_EN
  ,
  output logic [15:0] oCRC
`endif
);

  localparam int         BAR_W    = H_ACTIVE / 8;
  localparam logic [9:0] COL_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] ROW_LAST = 10'(V_ACTIVE - 1);
  localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    GAP
  } state_t;

  state_t state, state_next;

  logic [9:0]  col, row, bar_cnt;
  logic [2:0]  bar_idx;
  logic [1:0]  mode_q;
  logic [23:0] pix;
  logic [22:0] addr1, addr2;
  logic [7:0]  frame_cnt, gap_cnt;
  logic        frame_done;

  logic        accept, last_pixel, gap_done, frame_start;
  logic [9:0]  col_next, row_next, bar_cnt_next;
  logic [2:0]  bar_idx_next;
  logic [1:0]  mode_next;
  logic [23:0] pix_next;
  logic [7:0]  ramp;

  assign accept      = (state == RUN) && !iWR_FULL;
  assign last_pixel  = accept && (col == COL_LAST) && (row == ROW_LAST);
  assign gap_done    = (state == GAP) && (gap_cnt == GAP_LAST);
  assign frame_start = iEN && ((state == IDLE) || gap_done);

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iEN) state_next = RUN;
      RUN:     if (last_pixel) state_next = GAP;
      GAP:     if (gap_done) state_next = iEN ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Position of the pixel that will be presented next; the bar index rides a
  // sub-counter so the colour-bar pattern needs no divider.
  always_comb begin
    col_next     = col;
    row_next     = row;
    bar_cnt_next = bar_cnt;
    bar_idx_next = bar_idx;
    mode_next    = mode_q;
    if (frame_start) begin
      col_next     = 10'd0;
      row_next     = 10'd0;
      bar_cnt_next = 10'd0;
      bar_idx_next = 3'd0;
      mode_next    = iMODE;
    end else if (accept) begin
      if (col == COL_LAST) begin
        col_next     = 10'd0;
        bar_cnt_next = 10'd0;
        bar_idx_next = 3'd0;
        row_next     = (row == ROW_LAST) ? 10'd0 : row + 10'd1;
      end else begin
        col_next = col + 10'd1;
        if (bar_cnt == BAR_LAST) begin
          bar_cnt_next = 10'd0;
          bar_idx_next = bar_idx + 3'd1;
        end else begin
          bar_cnt_next = bar_cnt + 10'd1;
        end
      end
    end
  end

  always_comb begin
    pix_next = 24'h000000;
    ramp     = col_next[7:0] + frame_cnt;
    case (mode_next)
      2'd0: begin
        case (bar_idx_next)
          3'd0:    pix_next = 24'hFFFFFF;
          3'd1:    pix_next = 24'hFFFF00;
          3'd2:    pix_next = 24'h00FFFF;
          3'd3:    pix_next = 24'h00FF00;
          3'd4:    pix_next = 24'hFF00FF;
          3'd5:    pix_next = 24'hFF0000;
          3'd6:    pix_next = 24'h0000FF;
          default: pix_next = 24'h000000;
        endcase
      end
      2'd1:    pix_next = {col_next[9:2], row_next[8:1], 8'h80};
      2'd2:    pix_next = (col_next[5] ^ row_next[5] ^ frame_cnt[0]) ? 24'hFFFFFF : 24'h000000;
      default: pix_next = {ramp, ramp, ramp};
    endcase
  end

  // Everything except oWR freezes on a stalled cycle; addresses wrap to base after the last pixel.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      col        <= 10'd0;
      row        <= 10'd0;
      bar_cnt    <= 10'd0;
      bar_idx    <= 3'd0;
      mode_q     <= 2'd0;
      pix        <= 24'h000000;
      addr1      <= BASE1;
      addr2      <= BASE2;
      frame_cnt  <= 8'd0;
      frame_done <= 1'b0;
      gap_cnt    <= 8'd0;
    end else begin
      frame_done <= last_pixel;
      if (last_pixel) frame_cnt <= frame_cnt + 8'd1;
      gap_cnt <= (state == GAP) ? gap_cnt + 8'd1 : 8'd0;
      if (frame_start || accept) begin
        col     <= col_next;
        row     <= row_next;
        bar_cnt <= bar_cnt_next;
        bar_idx <= bar_idx_next;
        mode_q  <= mode_next;
        pix     <= pix_next;
      end
      if (frame_start || last_pixel) begin
        addr1 <= BASE1;
        addr2 <= BASE2;
      end else if (accept) begin
        addr1 <= addr1 + 23'd1;
        addr2 <= addr2 + 23'd1;
      end
    end
  end

`ifdef PATTERN_CRC_EN
  logic [15:0] crc_run, crc_acc;

  // MSB-first CRC-16-CCITT over the 24-bit {R,G,B} word being accepted this cycle.
  always_comb begin
    crc_acc = crc_run;
    for (int i = 23; i >= 0; i--) begin
      crc_acc = {crc_acc[14:0], 1'b0} ^ ((crc_acc[15] ^ pix[i]) ? 16'h1021 : 16'h0000);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      crc_run <= 16'hFFFF;
      oCRC    <= 16'hFFFF;
    end else begin
      if (frame_start)  crc_run <= 16'hFFFF;
      else if (accept)  crc_run <= crc_acc;
      if (last_pixel)   oCRC    <= crc_acc;
    end
  end
`endif

  assign oWR         = accept;
  assign oWR1_DATA   = pix[23:8];
  assign oWR2_DATA   = {pix[7:0], 8'h00};
  assign oWR1_ADDR   = addr1;
  assign oWR2_ADDR   = addr2;
  assign oCOL        = col;
  assign oROW        = row;
  assign oFRAME_DONE = frame_done;
  assign oFRAME_CNT  = frame_cnt;
  assign oBUSY       = (state != IDLE);

endmodule

// File: tb/tb_frame_pattern_writer.sv
// Scoreboard bench for frame_pattern_writer using a reduced 128x52 frame so whole frames fit the run.
module tb_frame_pattern_writer;

  localparam int          H = 128;
  localparam int          V = 52;
  localparam int          GAP = 16;
  localparam int          FRAME_PIX = H * V;
  localparam logic [22:0] B1 = 23'h000000;
  localparam logic [22:0] B2 = 23'h100000;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic        iEN = 1'b0;
  logic [1:0]  iMODE = 2'd0;
  logic        iWR_FULL = 1'b0;
  logic        oWR, oFRAME_DONE, oBUSY;
  logic [15:0] oWR1_DATA, oWR2_DATA;
  logic [22:0] oWR1_ADDR, oWR2_ADDR;
  logic [9:0]  oCOL, oROW;
  logic [7:0]  oFRAME_CNT;
`ifdef PATTERN_CRC_EN
  logic [15:0] oCRC, crc_seen, exp_crc;
`endif

  typedef struct packed {
    logic [15:0] d1;
    logic [15:0] d2;
    logic [22:0] a1;
    logic [22:0] a2;
    logic [9:0]  col;
    logic [9:0]  row;
  } pix_t;

  pix_t exp_q[$];
  pix_t obs[FRAME_PIX];
  pix_t held, bad_got, bad_exp;
  int   checks = 0, errors = 0;
  int   sb_err = 0, stall_err = 0, stall_cycles = 0;
  int   acc_idx = 0, done_count = 0, done_double = 0, idle_run = 0, first_gap = 0;
  int   exp_f = 0;
  bit   active = 1'b0, stall_chk = 1'b0, prev_done = 1'b0;

  always #5 iCLK = ~iCLK;

  frame_pattern_writer #(
    .H_ACTIVE(H), .V_ACTIVE(V), .BASE1(B1), .BASE2(B2), .GAP_CYCLES(GAP)
  ) dut (
    .iCLK(iCLK), .iRST(iRST), .iEN(iEN), .iMODE(iMODE), .iWR_FULL(iWR_FULL),
    .oWR(oWR), .oWR1_DATA(oWR1_DATA), .oWR2_DATA(oWR2_DATA),
    .oWR1_ADDR(oWR1_ADDR), .oWR2_ADDR(oWR2_ADDR), .oCOL(oCOL), .oROW(oROW),
    .oFRAME_DONE(oFRAME_DONE), .oFRAME_CNT(oFRAME_CNT), .oBUSY(oBUSY)
`ifdef PATTERN_CRC_EN
    , .oCRC(oCRC)
`endif
  );

  function automatic logic [23:0] model_rgb(input int mode, input int x, input int y, input int f);
    logic [7:0] v;
    case (mode)
      0: begin
        case (x / (H / 8))
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      1: return {8'((x >> 2) & 255), 8'((y >> 1) & 255), 8'h80};
      2: return ((((x >> 5) ^ (y >> 5) ^ f) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: begin
        v = 8'((x + f) % 256);
        return {v, v, v};
      end
    endcase
  endfunction

`ifdef PATTERN_CRC_EN
  function automatic logic [15:0] crc_model(input logic [15:0] crc_in, input logic [23:0] rgb);
    logic [15:0] c;
    c = crc_in;
    for (int b = 2; b >= 0; b--) begin
      c = c ^ {rgb[8*b +: 8], 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? (16'(c << 1) ^ 16'h1021) : 16'(c << 1);
    end
    return c;
  endfunction
`endif

  // Queue one whole frame of expected accepted words, in raster order.
  task automatic push_frame(input int mode, input int f);
    pix_t        p;
    logic [23:0] rgb;
`ifdef PATTERN_CRC_EN
    logic [15:0] c;
    c = 16'hFFFF;
`endif
    acc_idx = 0;
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        rgb   = model_rgb(mode, x, y, f);
        p.d1  = rgb[23:8];
        p.d2  = {rgb[7:0], 8'h00};
        p.a1  = B1 + 23'(y * H + x);
        p.a2  = B2 + 23'(y * H + x);
        p.col = 10'(x);
        p.row = 10'(y);
        exp_q.push_back(p);
`ifdef PATTERN_CRC_EN
        c = crc_model(c, rgb);
`endif
      end
    end
`ifdef PATTERN_CRC_EN
    exp_crc = c;
`endif
  endtask

  // Monitor: pops the scoreboard on each accepted word and watches that stalled cycles hold.
  always @(negedge iCLK) begin
    pix_t cur, e;
    if (iRST) begin
      active    = 1'b0;
      stall_chk = 1'b0;
      prev_done = 1'b0;
    end else begin
      cur = {oWR1_DATA, oWR2_DATA, oWR1_ADDR, oWR2_ADDR, oCOL, oROW};
      if (stall_chk && cur !== held) stall_err++;
      stall_chk = active && iWR_FULL;
      if (stall_chk) stall_cycles++;
      held = cur;
      if (oFRAME_DONE) begin
        done_count++;
        if (prev_done) done_double++;
`ifdef PATTERN_CRC_EN
        crc_seen = oCRC;
`endif
      end
      prev_done = oFRAME_DONE;
      if (oWR) begin
        if (exp_q.size() == 0) begin
          if (sb_err == 0) begin bad_got = cur; bad_exp = '0; end
          sb_err++;
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            if (sb_err == 0) begin bad_got = cur; bad_exp = e; end
            sb_err++;
          end
        end
        if (acc_idx == 0) first_gap = idle_run;
        if (acc_idx < FRAME_PIX) obs[acc_idx] = cur;
        acc_idx++;
        idle_run = 0;
        active = (exp_q.size() != 0);
      end else begin
        idle_run++;
      end
    end
  end

  task automatic wait_frame(input int budget, output bit ok);
    int start;
    start = done_count;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge iCLK); #1;
      if (done_count != start) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_pixels(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge iCLK); #1;
      if (acc_idx >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset;
    iRST = 1'b1; iEN = 1'b0; iWR_FULL = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    checks++; if (oWR !== 1'b0) begin errors++; $display("[TB] FAIL rst_wr got=%b exp=0", oWR); end
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%b exp=0", oBUSY); end
    checks++; if (oFRAME_DONE !== 1'b0) begin errors++; $display("[TB] FAIL rst_done got=%b exp=0", oFRAME_DONE); end
    checks++; if (oFRAME_CNT !== 8'd0) begin errors++; $display("[TB] FAIL rst_cnt got=%0d exp=0", oFRAME_CNT); end
    checks++; if (oCOL !== 10'd0 || oROW !== 10'd0) begin errors++; $display("[TB] FAIL rst_pos got=%0d,%0d exp=0,0", oCOL, oROW); end
    checks++; if (oWR1_ADDR !== B1 || oWR2_ADDR !== B2) begin errors++; $display("[TB] FAIL rst_addr got=%h,%h exp=%h,%h", oWR1_ADDR, oWR2_ADDR, B1, B2); end
    checks++; if (oWR1_DATA !== 16'h0 || oWR2_DATA !== 16'h0) begin errors++; $display("[TB] FAIL rst_data got=%h,%h exp=0,0", oWR1_DATA, oWR2_DATA); end
`ifdef PATTERN_CRC_EN
    checks++; if (oCRC !== 16'hFFFF) begin errors++; $display("[TB] FAIL rst_crc got=%h exp=ffff", oCRC); end
`endif
    iRST = 1'b0;
    @(posedge iCLK); #1;
  endtask

  task automatic test_bars;
    int sb0; bit ok;
    sb0 = sb_err;
    push_frame(0, exp_f);
    iMODE = 2'd0; iWR_FULL = 1'b0; iEN = 1'b1;
    wait_frame(FRAME_PIX + 100, ok);
    exp_f++;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bars_timeout got=no_done exp=done"); end
    checks++; if (sb_err != sb0) begin errors++; $display("[TB] FAIL bars_stream errors=%0d got=%h/%h c%0d r%0d exp=%h/%h c%0d r%0d", sb_err - sb0, bad_got.d1, bad_got.a1, bad_got.col, bad_got.row, bad_exp.d1, bad_exp.a1, bad_exp.col, bad_exp.row); end
    checks++; if (acc_idx != FRAME_PIX) begin errors++; $display("[TB] FAIL bars_count got=%0d exp=%0d", acc_idx, FRAME_PIX); end
    checks++; if (obs[0].d1 !== 16'hFFFF || obs[0].d2 !== 16'hFF00) begin errors++; $display("[TB] FAIL bars_p0_data got=%h,%h exp=ffff,ff00", obs[0].d1, obs[0].d2); end
    checks++; if (obs[0].a1 !== 23'h0 || obs[0].a2 !== 23'h100000) begin errors++; $display("[TB] FAIL bars_p0_addr got=%h,%h exp=0,100000", obs[0].a1, obs[0].a2); end
    checks++; if (obs[16].d1 !== 16'hFFFF || obs[16].d2 !== 16'h0000) begin errors++; $display("[TB] FAIL bars_yellow got=%h,%h exp=ffff,0000", obs[16].d1, obs[16].d2); end
    checks++; if (obs[127].d1 !== 16'h0000 || obs[127].d2 !== 16'h0000) begin errors++; $display("[TB] FAIL bars_black got=%h,%h exp=0000,0000", obs[127].d1, obs[127].d2); end
    checks++; if (obs[128].row !== 10'd1 || obs[128].col !== 10'd0 || obs[128].a1 !== 23'd128) begin errors++; $display("[TB] FAIL bars_row1 got=r%0d c%0d a%0d exp=r1 c0 a128", obs[128].row, obs[128].col, obs[128].a1); end
    checks++; if (obs[FRAME_PIX-1].a1 !== 23'd6655 || obs[FRAME_PIX-1].a2 !== 23'h1019FF) begin errors++; $display("[TB] FAIL bars_last_addr got=%h,%h exp=19ff,1019ff", obs[FRAME_PIX-1].a1, obs[FRAME_PIX-1].a2); end
    checks++; if (oFRAME_CNT !== 8'(exp_f)) begin errors++; $display("[TB] FAIL bars_cnt got=%0d exp=%0d", oFRAME_CNT, exp_f); end
`ifdef PATTERN_CRC_EN
    checks++; if (crc_seen !== exp_crc) begin errors++; $display("[TB] FAIL bars_crc got=%h exp=%h", crc_seen, exp_crc); end
`endif
    repeat (2) @(posedge iCLK);
    #1;
    checks++; if (done_double != 0) begin errors++; $display("[TB] FAIL bars_done_width got=%0d_long_pulses exp=0", done_double); end
  endtask

  task automatic test_gradient;
    int sb0; bit ok;
    sb0 = sb_err;
    push_frame(1, exp_f);
    iMODE = 2'd1;
    wait_frame(FRAME_PIX + 100, ok);
    exp_f++;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL grad_timeout got=no_done exp=done"); end
    checks++; if (sb_err != sb0) begin errors++; $display("[TB] FAIL grad_stream errors=%0d got=%h/%h c%0d r%0d exp=%h/%h c%0d r%0d", sb_err - sb0, bad_got.d1, bad_got.a1, bad_got.col, bad_got.row, bad_exp.d1, bad_exp.a1, bad_exp.col, bad_exp.row); end
    checks++; if (first_gap != GAP) begin errors++; $display("[TB] FAIL gap_len got=%0d exp=%0d", first_gap, GAP); end
    checks++; if (obs[0].a1 !== 23'h0 || obs[0].col !== 10'd0 || obs[0].row !== 10'd0) begin errors++; $display("[TB] FAIL grad_restart got=a%0d c%0d r%0d exp=a0 c0 r0", obs[0].a1, obs[0].col, obs[0].row); end
    checks++; if (obs[50*H+100].d1 !== 16'h1919 || obs[50*H+100].d2 !== 16'h8000) begin errors++; $display("[TB] FAIL grad_p100_50 got=%h,%h exp=1919,8000", obs[50*H+100].d1, obs[50*H+100].d2); end
`ifdef PATTERN_CRC_EN
    checks++; if (crc_seen !== exp_crc) begin errors++; $display("[TB] FAIL grad_crc got=%h exp=%h", crc_seen, exp_crc); end
`endif
  endtask

  task automatic test_backpressure;
    int sb0, st0, sc0, start; bit ok;
    sb0 = sb_err; st0 = stall_err; sc0 = stall_cycles;
    push_frame(1, exp_f);
    start = done_count; ok = 1'b0;
    for (int i = 0; i < 4 * FRAME_PIX; i++) begin
      @(posedge iCLK); #1;
      if (done_count != start) begin ok = 1'b1; break; end
      iWR_FULL = 1'($urandom_range(0, 1));
    end
    iWR_FULL = 1'b0;
    exp_f++;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_timeout got=no_done exp=done"); end
    checks++; if (sb_err != sb0) begin errors++; $display("[TB] FAIL bp_stream errors=%0d got=%h/%h c%0d r%0d exp=%h/%h c%0d r%0d", sb_err - sb0, bad_got.d1, bad_got.a1, bad_got.col, bad_got.row, bad_exp.d1, bad_exp.a1, bad_exp.col, bad_exp.row); end
    checks++; if (acc_idx != FRAME_PIX) begin errors++; $display("[TB] FAIL bp_count got=%0d exp=%0d", acc_idx, FRAME_PIX); end
    checks++; if (stall_err != st0) begin errors++; $display("[TB] FAIL bp_hold got=%0d_changes exp=0", stall_err - st0); end
    checks++; if (stall_cycles == sc0) begin errors++; $display("[TB] FAIL bp_stalls got=0 exp=>0"); end
    checks++; if (obs[50*H+100].d1 !== 16'h1919 || obs[50*H+100].d2 !== 16'h8000) begin errors++; $display("[TB] FAIL bp_p100_50 got=%h,%h exp=1919,8000", obs[50*H+100].d1, obs[50*H+100].d2); end
    checks++; if (oFRAME_CNT !== 8'(exp_f)) begin errors++; $display("[TB] FAIL bp_cnt got=%0d exp=%0d", oFRAME_CNT, exp_f); end
`ifdef PATTERN_CRC_EN
    checks++; if (crc_seen !== exp_crc) begin errors++; $display("[TB] FAIL bp_crc got=%h exp=%h", crc_seen, exp_crc); end
`endif
  endtask

  task automatic test_checker_mode_change;
    int sb0; bit ok, okp;
    sb0 = sb_err;
    push_frame(2, exp_f);
    iMODE = 2'd2;
    wait_frame(FRAME_PIX + 100, ok);
    exp_f++;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL chk0_timeout got=no_done exp=done"); end
    checks++; if (obs[32].d1 !== 16'h0000 || obs[32].d2 !== 16'h0000) begin errors++; $display("[TB] FAIL chk_odd_p32 got=%h,%h exp=0000,0000", obs[32].d1, obs[32].d2); end
    push_frame(2, exp_f);
    wait_pixels(3000, FRAME_PIX, okp);
    iMODE = 2'd3;
    wait_frame(FRAME_PIX + 100, ok);
    exp_f++;
    checks++; if (!ok || !okp) begin errors++; $display("[TB] FAIL chk1_timeout got=no_done exp=done"); end
    checks++; if (obs[32].d1 !== 16'hFFFF || obs[32].d2 !== 16'hFF00) begin errors++; $display("[TB] FAIL chk_even_p32 got=%h,%h exp=ffff,ff00", obs[32].d1, obs[32].d2); end
    push_frame(3, exp_f);
    wait_frame(FRAME_PIX + 100, ok);
    exp_f++;
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ramp_timeout got=no_done exp=done"); end
    checks++; if (obs[5].d1 !== 16'h0A0A || obs[5].d2 !== 16'h0A00) begin errors++; $display("[TB] FAIL ramp_p5 got=%h,%h exp=0a0a,0a00", obs[5].d1, obs[5].d2); end
    checks++; if (sb_err != sb0) begin errors++; $display("[TB] FAIL chk_stream errors=%0d got=%h/%h c%0d r%0d exp=%h/%h c%0d r%0d", sb_err - sb0, bad_got.d1, bad_got.a1, bad_got.col, bad_got.row, bad_exp.d1, bad_exp.a1, bad_exp.col, bad_exp.row); end
  endtask

  task automatic test_en_drop;
    int sb0; bit ok, okp;
    sb0 = sb_err;
    push_frame(3, exp_f);
    wait_pixels(20 * H, 2 * FRAME_PIX, okp);
    iEN = 1'b0;
    wait_frame(FRAME_PIX + 100, ok);
    exp_f++;
    checks++; if (!ok || !okp) begin errors++; $display("[TB] FAIL drop_timeout got=no_done exp=done"); end
    checks++; if (sb_err != sb0) begin errors++; $display("[TB] FAIL drop_stream errors=%0d got=%h/%h c%0d r%0d exp=%h/%h c%0d r%0d", sb_err - sb0, bad_got.d1, bad_got.a1, bad_got.col, bad_got.row, bad_exp.d1, bad_exp.a1, bad_exp.col, bad_exp.row); end
    checks++; if (oFRAME_CNT !== 8'(exp_f)) begin errors++; $display("[TB] FAIL drop_cnt got=%0d exp=%0d", oFRAME_CNT, exp_f); end
    repeat (GAP + 4) @(posedge iCLK);
    #1;
    checks++; if (oBUSY !== 1'b0 || oWR !== 1'b0) begin errors++; $display("[TB] FAIL drop_idle got=busy%b wr%b exp=busy0 wr0", oBUSY, oWR); end
    checks++; if (acc_idx != FRAME_PIX) begin errors++; $display("[TB] FAIL drop_count got=%0d exp=%0d", acc_idx, FRAME_PIX); end
  endtask

  task automatic test_reset_mid;
    int sb0, d0; bit okp;
    sb0 = sb_err;
    push_frame(0, exp_f);
    iMODE = 2'd0; iEN = 1'b1;
    wait_pixels(300, FRAME_PIX, okp);
    iRST = 1'b1; iEN = 1'b0;
    d0 = done_count;
    @(posedge iCLK); #1;
    checks++; if (!okp) begin errors++; $display("[TB] FAIL rmid_timeout got=%0d_pixels exp=300", acc_idx); end
    checks++; if (sb_err != sb0) begin errors++; $display("[TB] FAIL rmid_stream errors=%0d got=%h/%h exp=%h/%h", sb_err - sb0, bad_got.d1, bad_got.a1, bad_exp.d1, bad_exp.a1); end
    checks++; if (oWR !== 1'b0 || oBUSY !== 1'b0) begin errors++; $display("[TB] FAIL rmid_ctl got=wr%b busy%b exp=wr0 busy0", oWR, oBUSY); end
    checks++; if (oFRAME_CNT !== 8'd0) begin errors++; $display("[TB] FAIL rmid_cnt got=%0d exp=0", oFRAME_CNT); end
    checks++; if (oCOL !== 10'd0 || oROW !== 10'd0 || oWR1_ADDR !== B1 || oWR2_ADDR !== B2) begin errors++; $display("[TB] FAIL rmid_pos got=c%0d r%0d %h %h exp=c0 r0 %h %h", oCOL, oROW, oWR1_ADDR, oWR2_ADDR, B1, B2); end
    checks++; if (oWR1_DATA !== 16'h0 || oWR2_DATA !== 16'h0) begin errors++; $display("[TB] FAIL rmid_data got=%h,%h exp=0,0", oWR1_DATA, oWR2_DATA); end
    exp_q.delete();
    repeat (2) @(posedge iCLK);
    #1 iRST = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    checks++; if (done_count != d0 || oFRAME_DONE !== 1'b0) begin errors++; $display("[TB] FAIL rmid_nodone got=%0d_pulses exp=0", done_count - d0); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] frame_pattern_writer bench, %0dx%0d frame, gap %0d", H, V, GAP);
    test_reset();
    test_bars();
    test_gradient();
    test_backpressure();
    test_checker_mode_change();
    test_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
